// File: rtl/pk_sequencer.sv
// pk_sequencer: control FSM turning host store/fetch pulses into datapath strobes, CAM writes and flash handshakes.
// Latency: 3 cycles command-to-done on fail-fast paths, 9 cycles minimum on success, plus AES/flash wait time.
// Backpressure: commands are accepted only in IDLE; pulses arriving while busy are dropped.
module pk_sequencer #(
    parameter int ADDR_WIDTH    = 4,
    parameter int ENC_TIMEOUT   = 64,
    parameter int FLASH_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_store,
    input  logic                  cmd_fetch,
    input  logic                  match,
    input  logic                  ready_encryption,
    input  logic                  flash_ack,
    output logic                  flash_req,
    output logic                  flash_we,
    output logic                  flash_or_acc_reg,
    output logic                  flash_or_acc_sel,
    output logic                  flash_acc_reg,
    output logic                  flash_pass_reg,
    output logic                  pass_enc_reg,
    output logic                  new_old_pass_sel,
    output logic                  plain_reg,
    output logic                  local_master_reg,
    output logic                  local_master_sel,
    output logic                  out_reg,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] write_add,
    output logic                  boot_lood,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            err,
    output logic [ADDR_WIDTH:0]   entry_count,
    output logic                  full
);

    localparam logic [2:0] ERR_OK        = 3'd0;
    localparam logic [2:0] ERR_NOT_FOUND = 3'd1;
    localparam logic [2:0] ERR_FULL      = 3'd2;
    localparam logic [2:0] ERR_DUP       = 3'd3;
    localparam logic [2:0] ERR_ENC_TO    = 3'd4;
    localparam logic [2:0] ERR_FLASH_TO  = 3'd5;

    // One timer serves both wait states, so size it for the longer of the two.
    localparam int TMAX = (ENC_TIMEOUT > FLASH_TIMEOUT) ? ENC_TIMEOUT : FLASH_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] ENC_LAST   = TW'(ENC_TIMEOUT - 1);
    localparam logic [TW-1:0] FLASH_LAST = TW'(FLASH_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0] CAP  = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE, S_LOOKUP, S_CHECK, S_LATCH, S_ENC_WAIT, S_CAPTURE, S_FLASH_WR,
        S_CAM_WR, S_FLASH_RD, S_DEC_LATCH, S_ENC_LATCH, S_OUTPUT, S_DONE
    } state_t;

    state_t        state;
    logic          is_fetch;
    logic [TW-1:0] tmo;

    assign full = (entry_count == CAP);

    // Sequencer: every output is registered and set on the transition into the state that owns it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= S_IDLE;
            is_fetch         <= 1'b0;
            tmo              <= '0;
            flash_req        <= 1'b0;
            flash_we         <= 1'b0;
            flash_or_acc_reg <= 1'b0;
            flash_or_acc_sel <= 1'b0;
            flash_acc_reg    <= 1'b0;
            flash_pass_reg   <= 1'b0;
            pass_enc_reg     <= 1'b0;
            new_old_pass_sel <= 1'b0;
            plain_reg        <= 1'b0;
            local_master_reg <= 1'b0;
            local_master_sel <= 1'b0;
            out_reg          <= 1'b0;
            write_en         <= 1'b0;
            write_add        <= '0;
            boot_lood        <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= ERR_OK;
            entry_count      <= '0;
        end else begin
            flash_or_acc_reg <= 1'b0;
            flash_acc_reg    <= 1'b0;
            flash_pass_reg   <= 1'b0;
            pass_enc_reg     <= 1'b0;
            plain_reg        <= 1'b0;
            local_master_reg <= 1'b0;
            out_reg          <= 1'b0;
            write_en         <= 1'b0;
            done             <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Fetch wins a same-cycle collision.
                    if (cmd_fetch || cmd_store) begin
                        is_fetch <= cmd_fetch;
                        err      <= ERR_OK;
                        busy     <= 1'b1;
                        state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: state <= S_CHECK;
                S_CHECK: begin
                    if (is_fetch) begin
                        if (!match) begin
                            err <= ERR_NOT_FOUND; busy <= 1'b0; done <= 1'b1; state <= S_DONE;
                        end else begin
                            flash_req <= 1'b1; flash_we <= 1'b0; boot_lood <= 1'b1;
                            tmo <= '0; state <= S_FLASH_RD;
                        end
                    end else if (match) begin
                        err <= ERR_DUP; busy <= 1'b0; done <= 1'b1; state <= S_DONE;
                    end else if (full) begin
                        err <= ERR_FULL; busy <= 1'b0; done <= 1'b1; state <= S_DONE;
                    end else begin
                        new_old_pass_sel <= 1'b0; plain_reg <= 1'b1;
                        local_master_sel <= 1'b0; local_master_reg <= 1'b1;
                        flash_or_acc_sel <= 1'b1; flash_or_acc_reg <= 1'b1;
                        state <= S_LATCH;
                    end
                end
                S_LATCH, S_ENC_LATCH: begin
                    tmo   <= '0;
                    state <= S_ENC_WAIT;
                end
                S_ENC_WAIT: begin
                    // tmo==0 is the first wait cycle: a ready seen there is left over from before.
                    if (tmo != '0 && ready_encryption) begin
                        if (is_fetch) begin
                            out_reg <= 1'b1; state <= S_OUTPUT;
                        end else begin
                            flash_pass_reg <= 1'b1; flash_acc_reg <= 1'b1; state <= S_CAPTURE;
                        end
                    end else if (tmo == ENC_LAST) begin
                        err <= ERR_ENC_TO; busy <= 1'b0; done <= 1'b1; state <= S_DONE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    flash_req <= 1'b1; flash_we <= 1'b1; boot_lood <= 1'b0;
                    write_add <= entry_count[ADDR_WIDTH-1:0];
                    tmo <= '0; state <= S_FLASH_WR;
                end
                S_FLASH_WR: begin
                    if (flash_ack) begin
                        flash_req <= 1'b0; flash_we <= 1'b0;
                        write_en <= 1'b1; state <= S_CAM_WR;
                    end else if (tmo == FLASH_LAST) begin
                        flash_req <= 1'b0; flash_we <= 1'b0;
                        err <= ERR_FLASH_TO; busy <= 1'b0; done <= 1'b1; state <= S_DONE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_CAM_WR: begin
                    if (!full) entry_count <= entry_count + 1'b1;
                    busy <= 1'b0; done <= 1'b1; state <= S_DONE;
                end
                S_FLASH_RD: begin
                    if (flash_ack) begin
                        flash_req <= 1'b0; boot_lood <= 1'b0;
                        pass_enc_reg <= 1'b1; state <= S_DEC_LATCH;
                    end else if (tmo == FLASH_LAST) begin
                        flash_req <= 1'b0; boot_lood <= 1'b0;
                        err <= ERR_FLASH_TO; busy <= 1'b0; done <= 1'b1; state <= S_DONE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_DEC_LATCH: begin
                    // Inverse AES is combinational, so the decrypted value is ready to latch now.
                    new_old_pass_sel <= 1'b1; plain_reg <= 1'b1;
                    local_master_sel <= 1'b1; local_master_reg <= 1'b1;
                    state <= S_ENC_LATCH;
                end
                S_OUTPUT: begin
                    busy <= 1'b0; done <= 1'b1; state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pk_sequencer.sv
// tb_pk_sequencer: randomized store/fetch traffic against a timeline model of the sequencer.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_pk_sequencer;

    localparam int AW    = 4;
    localparam int CAP   = 16;
    localparam int ET    = 64;
    localparam int FT    = 255;
    localparam int NEVER = 100000;
    localparam int BOUND = 800;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cmd_store = 1'b0, cmd_fetch = 1'b0, match = 1'b0;
    logic ready_encryption = 1'b0, flash_ack = 1'b0;
    logic flash_req, flash_we, flash_or_acc_reg, flash_or_acc_sel, flash_acc_reg, flash_pass_reg;
    logic pass_enc_reg, new_old_pass_sel, plain_reg, local_master_reg, local_master_sel, out_reg;
    logic write_en, boot_lood, busy, done, full;
    logic [AW-1:0] write_add;
    logic [2:0]    err;
    logic [AW:0]   entry_count;
    logic [28:0]   all_out;

    pk_sequencer #(.ADDR_WIDTH(AW), .ENC_TIMEOUT(ET), .FLASH_TIMEOUT(FT)) dut (
        .clk(clk), .rst(rst), .cmd_store(cmd_store), .cmd_fetch(cmd_fetch), .match(match),
        .ready_encryption(ready_encryption), .flash_ack(flash_ack),
        .flash_req(flash_req), .flash_we(flash_we), .flash_or_acc_reg(flash_or_acc_reg),
        .flash_or_acc_sel(flash_or_acc_sel), .flash_acc_reg(flash_acc_reg),
        .flash_pass_reg(flash_pass_reg), .pass_enc_reg(pass_enc_reg),
        .new_old_pass_sel(new_old_pass_sel), .plain_reg(plain_reg),
        .local_master_reg(local_master_reg), .local_master_sel(local_master_sel),
        .out_reg(out_reg), .write_en(write_en), .write_add(write_add), .boot_lood(boot_lood),
        .busy(busy), .done(done), .err(err), .entry_count(entry_count), .full(full)
    );

    assign all_out = {flash_req, flash_we, flash_or_acc_reg, flash_or_acc_sel, flash_acc_reg,
                      flash_pass_reg, pass_enc_reg, new_old_pass_sel, plain_reg, local_master_reg,
                      local_master_sel, out_reg, write_en, write_add, boot_lood, busy, done, err,
                      entry_count, full};

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference CAM contents and the held select levels.
    int accounts[$];
    bit m_foa_sel = 1'b0, m_nop_sel = 1'b0, m_lm_sel = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic bit in_list(input int a);
        foreach (accounts[i]) if (accounts[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    // One command, cycle 0 = cycle the command is presented. rd: ready offset from first
    // encryption-wait cycle; ad: ack offset from first flash cycle (may be negative = early).
    task automatic run_op(input string nm, input bit fetch, input bit both, input int acct,
                          input int rd, input int ad, input bit stray);
        int w, f, r_abs, a_abs, tr, e_err, t_done, t_plain, t_pe, t_out, t_wen, e_freq, e_wa;
        int g_done, g_plain, g_pe, g_out, g_wen, g_wa, c_plain, c_pe, c_out, c_wen, c_freq;
        int c_boot, c_webad, busy_bad, g_lm_plain, g_err, g_cnt, g_full, idle_bad, t;
        bit hit;
        hit = in_list(acct);
        r_abs = NEVER; a_abs = -1000;
        t_plain = -1; t_pe = -1; t_out = -1; t_wen = -1; e_freq = 0; e_wa = -1;
        if (!fetch) begin
            if (hit) begin e_err = 3; t_done = 3; end
            else if (accounts.size() == CAP) begin e_err = 2; t_done = 3; end
            else begin
                t_plain = 3; w = 4;
                r_abs = (rd == NEVER) ? NEVER : w + rd;
                tr = (r_abs > w + 1) ? r_abs : w + 1;
                if (tr > w + ET - 1) begin e_err = 4; t_done = w + ET; end
                else begin
                    f = tr + 2;
                    a_abs = (ad == NEVER) ? -1000 : f + ad;
                    if (a_abs >= f && a_abs <= f + FT - 1) begin
                        e_err = 0; t_wen = a_abs + 1; t_done = a_abs + 2;
                        e_freq = a_abs - f + 1; e_wa = accounts.size();
                    end else begin
                        e_err = 5; t_done = f + FT; e_freq = FT;
                    end
                end
            end
        end else begin
            if (!hit) begin e_err = 1; t_done = 3; end
            else begin
                f = 3;
                a_abs = (ad == NEVER) ? -1000 : f + ad;
                if (a_abs >= f && a_abs <= f + FT - 1) begin
                    e_freq = a_abs - f + 1;
                    t_pe = a_abs + 1; t_plain = a_abs + 2; w = a_abs + 3;
                    r_abs = (rd == NEVER) ? NEVER : w + rd;
                    tr = (r_abs > w + 1) ? r_abs : w + 1;
                    if (tr > w + ET - 1) begin e_err = 4; t_done = w + ET; end
                    else begin e_err = 0; t_out = tr + 1; t_done = tr + 2; end
                end else begin
                    e_err = 5; t_done = f + FT; e_freq = FT;
                end
            end
        end

        g_done = -1; g_plain = -1; g_pe = -1; g_out = -1; g_wen = -1; g_wa = -1;
        c_plain = 0; c_pe = 0; c_out = 0; c_wen = 0; c_freq = 0; c_boot = 0; c_webad = 0;
        busy_bad = 0; g_lm_plain = -1; g_err = -1; g_cnt = -1; g_full = -1;
        match = hit;
        for (t = 0; t <= BOUND; t++) begin
            if (t > 0) @(negedge clk);
            if (busy !== ((t >= 1 && t < t_done) ? 1'b1 : 1'b0)) busy_bad++;
            if (plain_reg)    begin c_plain++; g_plain = t; g_lm_plain = local_master_sel; end
            if (pass_enc_reg) begin c_pe++; g_pe = t; end
            if (out_reg)      begin c_out++; g_out = t; end
            if (write_en)     begin c_wen++; g_wen = t; g_wa = write_add; end
            if (flash_req)    begin c_freq++; if (flash_we !== !fetch) c_webad++; end
            if (boot_lood)    c_boot++;
            if (done) begin
                g_done = t; g_err = err; g_cnt = entry_count; g_full = full;
                break;
            end
            cmd_fetch        = (t == 0 && fetch) || (stray && t == 2 && acct[0]);
            cmd_store        = (t == 0 && (!fetch || both)) || (stray && t == 2 && !acct[0]);
            ready_encryption = (t >= r_abs);
            flash_ack        = (t == a_abs);
        end
        cmd_fetch = 1'b0; cmd_store = 1'b0; ready_encryption = 1'b0; flash_ack = 1'b0;

        if (!fetch && e_err == 0) accounts.push_back(acct);
        if (t_plain >= 0) begin
            if (fetch) begin m_nop_sel = 1'b1; m_lm_sel = 1'b1; end
            else begin m_foa_sel = 1'b1; m_nop_sel = 1'b0; m_lm_sel = 1'b0; end
        end

        chk({nm, ".done_t"}, g_done, t_done);
        chk({nm, ".err"}, g_err, e_err);
        chk({nm, ".entry_count"}, g_cnt, accounts.size());
        chk({nm, ".full"}, g_full, accounts.size() == CAP);
        chk({nm, ".busy"}, busy_bad, 0);
        chk({nm, ".wen_cnt"}, c_wen, (t_wen >= 0) ? 1 : 0);
        chk({nm, ".wen_t"}, g_wen, t_wen);
        chk({nm, ".write_add"}, g_wa, e_wa);
        chk({nm, ".plain_cnt"}, c_plain, (t_plain >= 0) ? 1 : 0);
        chk({nm, ".plain_t"}, g_plain, t_plain);
        chk({nm, ".lm_sel_at_plain"}, g_lm_plain, (t_plain >= 0) ? int'(fetch) : -1);
        chk({nm, ".pass_enc_t"}, g_pe, t_pe);
        chk({nm, ".pass_enc_cnt"}, c_pe, (t_pe >= 0) ? 1 : 0);
        chk({nm, ".out_t"}, g_out, t_out);
        chk({nm, ".out_cnt"}, c_out, (t_out >= 0) ? 1 : 0);
        chk({nm, ".flash_req_cycles"}, c_freq, e_freq);
        chk({nm, ".flash_we_bad"}, c_webad, 0);
        chk({nm, ".boot_lood_cycles"}, c_boot, fetch ? e_freq : 0);
        chk({nm, ".sels"}, {flash_or_acc_sel, new_old_pass_sel, local_master_sel},
            {m_foa_sel, m_nop_sel, m_lm_sel});

        idle_bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) idle_bad++;
        end
        chk({nm, ".idle_after"}, idle_bad, 0);
    endtask

    initial begin
        int nd;
        int acct, rd, ad, sel;
        bit fch;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", all_out, 0);
        rst = 1'b1;
        @(negedge clk);

        // Directed sequence.
        run_op("store_first", 1'b0, 1'b0, 1, 3, 5, 1'b0);
        run_op("store_dup", 1'b0, 1'b0, 1, 0, 0, 1'b0);
        run_op("fetch_hit_stale", 1'b1, 1'b0, 1, 0, 2, 1'b0);
        run_op("fetch_miss", 1'b1, 1'b0, 99, 0, 0, 1'b0);
        run_op("store_enc_to", 1'b0, 1'b0, 2, NEVER, 0, 1'b0);
        run_op("fetch_flash_to", 1'b1, 1'b0, 1, 0, NEVER, 1'b0);
        run_op("store_flash_to", 1'b0, 1'b0, 3, 1, NEVER, 1'b0);
        run_op("fetch_enc_to", 1'b1, 1'b0, 1, NEVER, 0, 1'b0);
        run_op("store_early_ack", 1'b0, 1'b0, 4, 2, -2, 1'b0);
        run_op("collision", 1'b1, 1'b1, 1, 1, 1, 1'b0);
        run_op("store_busy_cmd", 1'b0, 1'b0, 6, 2, 3, 1'b1);
        run_op("fetch_busy_cmd", 1'b1, 1'b0, 6, 1, 1, 1'b1);

        // Asynchronous reset in the encryption wait.
        chk("pre_reset_count", entry_count, accounts.size());
        cmd_store = 1'b1; match = 1'b0;
        @(negedge clk);
        cmd_store = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_op_busy", busy, 1);
        #1 rst = 1'b0;
        #1 chk("mid_op_reset_outputs", all_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) nd++;
        end
        chk("no_done_after_reset", nd, 0);
        chk("count_after_reset", entry_count, 0);
        accounts.delete();
        m_foa_sel = 1'b0; m_nop_sel = 1'b0; m_lm_sel = 1'b0;

        // Random traffic.
        for (int i = 0; i < 50; i++) begin
            fch  = ($urandom_range(0, 9) < 4);
            acct = $urandom_range(0, 23);
            sel  = $urandom_range(0, 15);
            rd   = (sel == 0) ? NEVER : $urandom_range(0, 6);
            sel  = $urandom_range(0, 15);
            ad   = (sel == 0) ? NEVER : ((sel == 1) ? -2 : $urandom_range(0, 6));
            run_op("rand", fch, $urandom_range(0, 7) == 0, acct, rd, ad, $urandom_range(0, 3) == 0);
        end

        // Fill to capacity from empty, then one more store.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        accounts.delete();
        m_foa_sel = 1'b0; m_nop_sel = 1'b0; m_lm_sel = 1'b0;
        for (int i = 0; i < CAP; i++)
            run_op("fill", 1'b0, 1'b0, 200 + i, $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
        run_op("store_full", 1'b0, 1'b0, 300, 1, 1, 1'b0);
        run_op("fetch_when_full", 1'b1, 1'b0, 205, 2, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
